// File: rtl/pacman_pkg.sv
// Shared game-flow types and default tuning constants for the pacman datapath.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESPAWN   = 3'd1,
    READY     = 3'd2,
    PLAY      = 3'd3,
    DYING     = 3'd4,
    GAME_OVER = 3'd5,
    WON       = 3'd6
  } game_state_t;

  localparam int START_LIVES_DEF  = 3;
  localparam int READY_FRAMES_DEF = 120;
  localparam int DEATH_FRAMES_DEF = 96;
  localparam int DEATH_DIV_DEF    = 8;

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// one-cycle tick per rising edge of frame_clk.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Tick is visible in the cycle following the second synchroniser edge
  assign frame_tick = sync2_q & ~prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: READY/PLAY/DYING/GAME_OVER/WON sequencing, lives,
// mover freeze/respawn and death-animation index. Collisions are gathered
// across a frame and only acted on at the frame tick.
module game_state_ctrl
  import pacman_pkg::*;
#(
  parameter int START_LIVES  = START_LIVES_DEF,
  parameter int READY_FRAMES = READY_FRAMES_DEF,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int DEATH_DIV    = DEATH_DIV_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       lose_game_in,
  input  logic       pellets_cleared,
  input  logic       start_pressed,
  output logic [2:0] state,
  output logic       freeze,
  output logic       respawn,
  output logic [1:0] lives,
  output logic [3:0] death_frame,
  output logic       show_ready,
  output logic       game_over,
  output logic       game_won
);

  game_state_t state_q;
  game_state_t state_d;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  frame_cnt_d;
  logic        hit_latch_q;
  logic        hit_latch_d;
  logic [1:0]  lives_q;
  logic [1:0]  lives_d;
  logic        lives_dec;
  logic        lives_reload;
  logic        frame_tick;

  // Frame counter saturates rather than wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Sprite index for the death animation, clamped to the last sprite
  function automatic logic [3:0] death_idx(input logic [7:0] cnt);
    int idx;
    idx = int'(cnt) / DEATH_DIV;
    if (idx > DEATH_FRAMES / DEATH_DIV - 1)
      idx = DEATH_FRAMES / DEATH_DIV - 1;
    return 4'(idx);
  endfunction

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  // Next-state and lives-control decode
  always_comb begin
    state_d      = state_q;
    lives_dec    = 1'b0;
    lives_reload = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pressed) state_d = RESPAWN;
      end
      RESPAWN: begin
        state_d = READY;
      end
      READY: begin
        if (frame_tick && (frame_cnt_q == 8'(READY_FRAMES - 1))) state_d = PLAY;
      end
      PLAY: begin
        if (frame_tick) begin
          if (pellets_cleared) begin
            state_d = WON;
          end else if (hit_latch_q | lose_game_in) begin
            state_d   = DYING;
            lives_dec = 1'b1;
          end
        end
      end
      DYING: begin
        if (frame_tick && (frame_cnt_q == 8'(DEATH_FRAMES - 1)))
          state_d = (lives_q == 2'd0) ? GAME_OVER : RESPAWN;
      end
      GAME_OVER, WON: begin
        if (start_pressed) begin
          state_d      = RESPAWN;
          lives_reload = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter, hit latch and lives next values
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q)
      frame_cnt_d = 8'd0;
    else if (frame_tick && ((state_q == READY) || (state_q == DYING)))
      frame_cnt_d = sat_inc(frame_cnt_q);

    hit_latch_d = frame_tick ? 1'b0
                             : (hit_latch_q | (lose_game_in && (state_q == PLAY)));

    lives_d = lives_q;
    if (lives_reload)   lives_d = 2'(START_LIVES);
    else if (lives_dec) lives_d = lives_q - 2'd1;
  end

  // State, bookkeeping and outputs registered from the next state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      hit_latch_q <= 1'b0;
      lives_q     <= 2'(START_LIVES);
      freeze      <= 1'b1;
      respawn     <= 1'b0;
      death_frame <= 4'd0;
      show_ready  <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      hit_latch_q <= hit_latch_d;
      lives_q     <= lives_d;
      freeze      <= (state_d != PLAY);
      respawn     <= (state_d == RESPAWN);
      death_frame <= (state_d == DYING) ? death_idx(frame_cnt_d) : 4'd0;
      show_ready  <= (state_d == READY);
      game_over   <= (state_d == GAME_OVER);
      game_won    <= (state_d == WON);
    end
  end

  assign state = state_q;
  assign lives = lives_q;

  // A death can only be entered with at least one life left
  a_no_underflow: assert property (@(posedge Clk) disable iff (Reset)
    !(lives_dec && (lives_q == 2'd0)));

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Game-flow controller that sits directly downstream of the entity selector and consumes its per-pixel lose_game_in collision flag. Per-pixel collision hits are accumulated across a video frame and acted on at the frame boundary. The block runs the READY / PLAY / DYING / GAME_OVER / WON flow, owns the lives counter, and drives the freeze and respawn controls for the entity movers, the death-animation frame index for the sprite ROMs, and the status flags for the HUD.

Parameters:
START_LIVES, 3, lives loaded at reset and at restart (1..3)
READY_FRAMES, 120, frame ticks spent frozen with the READY banner
DEATH_FRAMES, 96, frame ticks spent in the death animation
DEATH_DIV, 8, frame ticks per death-animation sprite frame

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  VGA vertical-sync-derived frame strobe (asynchronous to Clk)
lose_game_in  in  1  per-pixel pacman/ghost overlap flag from the entity selector
pellets_cleared  in  1  level; high when the pellet count is 0
start_pressed  in  1  level; start key held
state  out  3  current game_state_t encoding
freeze  out  1  movers hold position while high
respawn  out  1  one-Clk pulse; movers reload their start positions
lives  out  2  remaining lives
death_frame  out  4  death-animation sprite index
show_ready  out  1  READY banner enable
game_over  out  1  high in GAME_OVER
game_won  out  1  high in WON

Behaviour:
- Reset values: state=IDLE, freeze=1, respawn=0, lives=START_LIVES, death_frame=0, show_ready=0, game_over=0, game_won=0, frame_cnt=0, hit_latch=0, synchroniser flops=0.
- frame_tick: frame_clk goes through a 2-flop synchroniser followed by a rising-edge detect. frame_tick is high for exactly one Clk cycle, 2 Clk edges after frame_clk rises. A frame_clk level held high produces no further ticks.
- hit_latch:
  - Set on any Clk cycle with lose_game_in=1 while state=PLAY.
  - Cleared on every frame_tick.
  - A hit in the same cycle as the frame_tick counts toward that tick.
- frame_cnt: 8-bit. Cleared on every state change. Increments on frame_tick in READY and DYING. Saturates at 255.
- All outputs are registered and decoded from the next state, so they change in the same cycle as state.
- IDLE: freeze=1. start_pressed=1 -> RESPAWN.
- RESPAWN: lasts exactly 1 cycle. respawn=1, freeze=1. Next state is READY.
- READY: freeze=1, show_ready=1. Leaves on the frame_tick where frame_cnt==READY_FRAMES-1 -> PLAY.
- PLAY: freeze=0. Evaluated only on frame_tick, with this priority:
  1. pellets_cleared -> WON.
  2. (hit_latch | lose_game_in) -> DYING, and lives decrements by 1 on entry.
  3. Otherwise stay in PLAY. Collisions between ticks have no effect until the tick.
- DYING: freeze=1. death_frame = frame_cnt/DEATH_DIV, saturating at DEATH_FRAMES/DEATH_DIV-1 (11). Leaves on the frame_tick where frame_cnt==DEATH_FRAMES-1: lives==0 -> GAME_OVER, else -> RESPAWN. death_frame returns to 0 on exit.
- GAME_OVER: game_over=1, freeze=1. WON: game_won=1, freeze=1. In either state, start_pressed=1 -> reload lives=START_LIVES and go to RESPAWN.
- lives never underflows: a decrement from 0 is impossible by construction; assert on it in simulation.
- start_pressed in READY, PLAY or DYING is ignored.
- Reset asserted in any state returns every register to its reset value on the next Clk edge. No respawn pulse is produced by reset itself.

Decomposition:
- pacman_pkg holds:
  - game_state_t enum, 3 bits: IDLE=0, RESPAWN=1, READY=2, PLAY=3, DYING=4, GAME_OVER=5, WON=6.
  - Default constants for START_LIVES, READY_FRAMES, DEATH_FRAMES, DEATH_DIV.
- Sub-module frame_tick_gen (Clk, Reset, frame_clk -> frame_tick): synchroniser plus edge detect, reusable by the ghost movers.

Test Plan:
- Reset, then start_pressed for 1 cycle -> respawn high for exactly 1 cycle, then show_ready=1 for 120 frame ticks, then state=PLAY with freeze=0 and lives=3.
- In PLAY, pulse lose_game_in for 1 Clk mid-frame -> state stays PLAY until the next frame_tick, then DYING with lives=2. death_frame steps 0..11, one step every 8 ticks. After 96 ticks: RESPAWN (1-cycle respawn), then READY.
- Three collisions in successive PLAY periods -> third DYING ends in GAME_OVER, game_over=1, lives=0. start_pressed -> lives=3, respawn pulse, READY.
- pellets_cleared and lose_game_in both high at a frame_tick -> WON, game_won=1, lives unchanged.
- frame_clk held high for 10 frames' worth of cycles -> exactly one frame_tick. Toggling frame_clk 1 Clk before vs 1 Clk after a Clk edge -> tick lands 2 Clk edges after the rise.
- Reset asserted mid-DYING at frame_cnt=40 -> next cycle state=IDLE, lives=3, death_frame=0, freeze=1, respawn=0.
